jump_request_ctrl: RTL and testbench
====================================

Name: jump_request_ctrl

Overview:
Upstream of player_move. Turns raw keyboard key levels (space, enter) into clean small_jump / high_jump commands. Issues at most one jump per landing and holds each command until the player actually leaves the ground. Enforces a frame-counted cooldown after landing and keeps a jump counter for the score/HUD logic.

Parameters:
GROUND_Y, 400, player topLeftY (pixels) when standing on the ground.
COOLDOWN_FRAMES, 4, start_Of_frame pulses after landing before a new jump may issue.
ISSUE_TIMEOUT, 8, max start_Of_frame pulses a command is held without lift-off.

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
start_Of_frame  in  1  one-clock pulse per frame
space_key  in  1  level, 1 while space is held
enter_key  in  1  level, 1 while enter is held
playerY  in  11  current player topLeftY from player_move
small_jump  out  1  small-jump command level
high_jump  out  1  high-jump command level
jump_busy  out  1  1 in any state other than IDLE
jump_count  out  8  number of jumps issued, wrapping

Behaviour:
- Reset (async, resetN=0):
  - all outputs 0; state IDLE.
  - key-history registers 0; pending request cleared; frame counter 0.
- Edge detect: key registered every clk; rise = key & ~key_d. A held key produces exactly one request.
- grounded = (playerY == GROUND_Y), combinational.
- Request capture, pending type: NONE/SMALL/HIGH.
  - enter rise -> HIGH.
  - space rise -> SMALL only if pending is NONE.
  - Both rises in the same clk -> HIGH.
  - HIGH is never downgraded.
- Capture window: pending is only captured in IDLE; rises in other states are dropped (see optional feature).
- FSM:
  - IDLE: pending != NONE and grounded -> ISSUE. On entry, assert high_jump or small_jump per pending, clear pending, jump_count+1 (255->0), frame counter 0.
  - IDLE with pending and not grounded: hold pending, stay in IDLE.
  - ISSUE: keep the command output asserted.
    - Not grounded -> AIRBORNE; clear command output on that clk.
    - Else on each start_Of_frame, counter+1. When counter reaches ISSUE_TIMEOUT -> IDLE; clear output; count is not decremented.
  - AIRBORNE: outputs 0. grounded -> COOLDOWN, counter 0.
  - COOLDOWN: each start_Of_frame counter+1. Counter == COOLDOWN_FRAMES -> IDLE. Leaving ground here (external push) -> AIRBORNE.
- small_jump and high_jump are never both 1. Command is registered and is 1 for the whole ISSUE state, 0 elsewhere.
- Latency: key rise at clk n -> command high at clk n+2 (edge register + state register) when IDLE and grounded.
- COOLDOWN_FRAMES=0: COOLDOWN exits to IDLE on the next clk.
- Reset mid-jump returns to IDLE with outputs 0 at once; player_move resets alongside.

Optional Feature:
Macro JUMP_BUFFER_EN.
- Defined: a rise arriving in ISSUE, AIRBORNE or COOLDOWN is stored in a one-deep buffer, using the same HIGH-over-SMALL rule. On entry to IDLE the buffer moves into pending and clears, so it issues on the next grounded clk.
- Undefined: such rises are discarded and no buffer register exists.

Test Plan:
1. Reset, playerY=400, space rise at clk 10 -> small_jump=1 at clk 12, jump_count=1, jump_busy=1; drive playerY=399 -> small_jump=0 next clk, state AIRBORNE.
2. space and enter rise in same clk, grounded -> high_jump=1, small_jump=0 throughout ISSUE.
3. Land (playerY=400) then press enter after 2 frames, COOLDOWN_FRAMES=4:
   - without JUMP_BUFFER_EN -> no command;
   - with it -> high_jump asserts on the clk after the 4th start_Of_frame following landing.
4. Hold space for 20 frames through a full jump -> exactly one small_jump issue, jump_count=1.
5. playerY held at 400 during ISSUE, 8 start_Of_frame pulses -> back to IDLE, command 0, jump_count stays 1.
6. 256 issued jumps -> jump_count wraps to 0. Assert resetN low mid-AIRBORNE -> all outputs 0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/jump_request_ctrl_if.sv
// Keyboard/frame/position inputs and jump command outputs of jump_request_ctrl.
// master drives the inputs, slave is the controller itself.
interface jump_request_ctrl_if;
    logic        start_Of_frame;
    logic        space_key;
    logic        enter_key;
    logic [10:0] playerY;
    logic        small_jump;
    logic        high_jump;
    logic        jump_busy;
    logic [7:0]  jump_count;

    modport master (
        output start_Of_frame, space_key, enter_key, playerY,
        input  small_jump, high_jump, jump_busy, jump_count
    );

    modport slave (
        input  start_Of_frame, space_key, enter_key, playerY,
        output small_jump, high_jump, jump_busy, jump_count
    );
endinterface

// File: rtl/jump_request_ctrl.sv
// Turns space/enter key levels into one held small/high jump command per landing.
// Optional macro JUMP_BUFFER_EN keeps one request pressed while busy for the next IDLE.
module jump_request_ctrl #(
    parameter int unsigned GROUND_Y        = 400,
    parameter int unsigned COOLDOWN_FRAMES = 4,
    parameter int unsigned ISSUE_TIMEOUT   = 8
) (
    input logic               clk,
    input logic               resetN,
    jump_request_ctrl_if.slave jif
);
    localparam int unsigned CntMax = (ISSUE_TIMEOUT > COOLDOWN_FRAMES) ?
                                     ISSUE_TIMEOUT : COOLDOWN_FRAMES;
    localparam int unsigned CntW   = $clog2(CntMax + 2);

    typedef enum logic [1:0] {StIdle, StIssue, StAirborne, StCooldown} state_e;
    typedef enum logic [1:0] {ReqNone, ReqSmall, ReqHigh} req_e;

    // HIGH always wins and is never downgraded; SMALL only fills an empty slot.
    function automatic req_e merge_req(input req_e cur, input logic s, input logic e);
        if (e) return ReqHigh;
        if (s && (cur == ReqNone)) return ReqSmall;
        return cur;
    endfunction

    state_e            state_q, state_d;
    req_e              pending_q, pending_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              space_d, enter_d;
    logic              small_q, small_d, high_q, high_d;
    logic [7:0]        count_q, count_d;

    logic              grounded, space_rise, enter_rise, sof;
    logic [CntW-1:0]   cnt_inc;
    logic              issue_done, cool_done, enter_idle;
    req_e              refill;

    assign grounded   = (jif.playerY == 11'(GROUND_Y));
    assign space_rise = jif.space_key & ~space_d;
    assign enter_rise = jif.enter_key & ~enter_d;
    assign sof        = jif.start_Of_frame;
    assign cnt_inc    = cnt_q + CntW'(1);
    assign issue_done = (cnt_q == CntW'(ISSUE_TIMEOUT)) ||
                        (sof && (cnt_inc == CntW'(ISSUE_TIMEOUT)));
    assign cool_done  = (cnt_q == CntW'(COOLDOWN_FRAMES)) ||
                        (sof && (cnt_inc == CntW'(COOLDOWN_FRAMES)));

`ifdef JUMP_BUFFER_EN
    req_e buf_q, buf_d, buf_merged;

    assign buf_merged = merge_req(buf_q, space_rise, enter_rise);
    assign refill     = buf_merged;

    always_comb begin
        buf_d = buf_q;
        if (enter_idle)             buf_d = ReqNone;
        else if (state_q != StIdle) buf_d = buf_merged;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) buf_q <= ReqNone;
        else         buf_q <= buf_d;
    end
`else
    assign refill = ReqNone;
`endif

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        cnt_d      = cnt_q;
        small_d    = small_q;
        high_d     = high_q;
        count_d    = count_q;
        enter_idle = 1'b0;
        case (state_q)
            StIdle: begin
                if ((pending_q != ReqNone) && grounded) begin
                    state_d   = StIssue;
                    small_d   = (pending_q == ReqSmall);
                    high_d    = (pending_q == ReqHigh);
                    pending_d = ReqNone;
                    count_d   = count_q + 8'd1;
                    cnt_d     = '0;
                end else begin
                    pending_d = merge_req(pending_q, space_rise, enter_rise);
                end
            end
            StIssue: begin
                if (!grounded) begin
                    state_d = StAirborne;
                    small_d = 1'b0;
                    high_d  = 1'b0;
                end else if (issue_done) begin
                    state_d    = StIdle;
                    small_d    = 1'b0;
                    high_d     = 1'b0;
                    pending_d  = refill;
                    enter_idle = 1'b1;
                end else if (sof) begin
                    cnt_d = cnt_inc;
                end
            end
            StAirborne: begin
                if (grounded) begin
                    state_d = StCooldown;
                    cnt_d   = '0;
                end
            end
            StCooldown: begin
                if (!grounded) begin
                    state_d = StAirborne;
                end else if (cool_done) begin
                    state_d    = StIdle;
                    pending_d  = refill;
                    enter_idle = 1'b1;
                end else if (sof) begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= StIdle;
            pending_q <= ReqNone;
            cnt_q     <= '0;
            space_d   <= 1'b0;
            enter_d   <= 1'b0;
            small_q   <= 1'b0;
            high_q    <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            space_d   <= jif.space_key;
            enter_d   <= jif.enter_key;
            small_q   <= small_d;
            high_q    <= high_d;
            count_q   <= count_d;
        end
    end

    assign jif.small_jump = small_q;
    assign jif.high_jump  = high_q;
    assign jif.jump_busy  = (state_q != StIdle);
    assign jif.jump_count = count_q;
endmodule

// File: tb/tb_jump_request_ctrl.sv
// Randomized and directed bench for jump_request_ctrl against a frame-level reference model.
// Honours JUMP_BUFFER_EN the same way as the design.
module tb_jump_request_ctrl;
`ifdef JUMP_BUFFER_EN
    localparam bit BufEn = 1'b1;
`else
    localparam bit BufEn = 1'b0;
`endif
    localparam int GroundY  = 400;
    localparam int CoolFr   = 4;
    localparam int Timeout  = 8;
    localparam int MIdle = 0, MIssue = 1, MAir = 2, MCool = 3;

    logic clk;
    logic resetN;
    jump_request_ctrl_if jif();

    jump_request_ctrl dut (
        .clk    (clk),
        .resetN (resetN),
        .jif    (jif)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: which phase of the jump the player is in, plus queued requests.
    int         m_mode, m_pend, m_buf, m_kind, m_frames;
    bit         m_sp_prev, m_en_prev;
    logic [7:0] m_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int merge(input int p, input bit s, input bit e);
        if (e) return 2;
        if (s && p == 0) return 1;
        return p;
    endfunction

    task automatic model_reset();
        m_mode = MIdle; m_pend = 0; m_buf = 0; m_kind = 0; m_frames = 0;
        m_sp_prev = 0; m_en_prev = 0; m_count = 8'd0;
    endtask

    task automatic model_go_idle();
        m_mode = MIdle;
        m_pend = m_buf;
        m_buf  = 0;
    endtask

    task automatic model_step();
        bit sr, er, g;
        int sof;
        sr = jif.space_key && !m_sp_prev;
        er = jif.enter_key && !m_en_prev;
        m_sp_prev = jif.space_key;
        m_en_prev = jif.enter_key;
        g   = (int'(jif.playerY) == GroundY);
        sof = jif.start_Of_frame ? 1 : 0;
        if (m_mode == MIdle) begin
            if (m_pend != 0 && g) begin
                m_mode = MIssue; m_kind = m_pend; m_pend = 0;
                m_count = m_count + 8'd1; m_frames = 0;
            end else begin
                m_pend = merge(m_pend, sr, er);
            end
        end else begin
            if (BufEn) m_buf = merge(m_buf, sr, er);
            if (m_mode == MIssue) begin
                if (!g) m_mode = MAir;
                else begin
                    m_frames += sof;
                    if (m_frames >= Timeout) model_go_idle();
                end
            end else if (m_mode == MAir) begin
                if (g) begin m_mode = MCool; m_frames = 0; end
            end else begin
                if (!g) m_mode = MAir;
                else begin
                    m_frames += sof;
                    if (m_frames >= CoolFr) model_go_idle();
                end
            end
        end
    endtask

    function automatic logic [10:0] model_out();
        logic s, h, b;
        s = (m_mode == MIssue) && (m_kind == 1);
        h = (m_mode == MIssue) && (m_kind == 2);
        b = (m_mode != MIdle);
        return {s, h, b, m_count};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge resetN);
            if (!resetN) model_reset();
            else         model_step();
        end
    end

    // Per-cycle compare against the model, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (resetN === 1'b1) begin
                check("cycle_outputs",
                      32'({jif.small_jump, jif.high_jump, jif.jump_busy, jif.jump_count}),
                      32'(model_out()));
                check("cmd_exclusive", 32'(jif.small_jump & jif.high_jump), 32'(0));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame();
        jif.start_Of_frame = 1'b1;
        tick(1);
        jif.start_Of_frame = 1'b0;
        tick(3);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 resetN = 1'b0;
        jif.start_Of_frame = 1'b0;
        jif.space_key = 1'b0;
        jif.enter_key = 1'b0;
        jif.playerY = 11'd400;
        tick(2);
        resetN = 1'b1;
    endtask

    // Press space, issue, lift off and land, then sit out the cooldown.
    task automatic full_jump();
        jif.space_key = 1'b1;
        tick(2);
        jif.space_key = 1'b0;
        jif.playerY = 11'd399;
        tick(1);
        jif.playerY = 11'd400;
        tick(1);
        repeat (CoolFr) frame();
    endtask

    initial begin
        bit gnd;
        resetN = 1'b1;
        jif.start_Of_frame = 1'b0;
        jif.space_key = 1'b0;
        jif.enter_key = 1'b0;
        jif.playerY = 11'd400;
        #2 resetN = 1'b0;
        tick(2);
        resetN = 1'b1;
        tick(1);
        check("reset_small", 32'(jif.small_jump), 32'(0));
        check("reset_high",  32'(jif.high_jump),  32'(0));
        check("reset_busy",  32'(jif.jump_busy),  32'(0));
        check("reset_count", 32'(jif.jump_count), 32'(0));

        // Small jump: two-clock latency, then lift-off drops the command.
        jif.space_key = 1'b1;
        tick(1);
        check("t1_latency_small", 32'(jif.small_jump), 32'(0));
        tick(1);
        check("t1_small",  32'(jif.small_jump), 32'(1));
        check("t1_count",  32'(jif.jump_count), 32'(1));
        check("t1_busy",   32'(jif.jump_busy),  32'(1));
        jif.playerY = 11'd399;
        tick(1);
        check("t1_air_small", 32'(jif.small_jump), 32'(0));
        check("t1_air_busy",  32'(jif.jump_busy),  32'(1));
        jif.playerY = 11'd400;
        jif.space_key = 1'b0;
        repeat (5) frame();
        check("t1_idle_busy", 32'(jif.jump_busy), 32'(0));

        // Both keys together: high wins for the whole issue phase.
        do_reset();
        jif.space_key = 1'b1;
        jif.enter_key = 1'b1;
        tick(2);
        check("t2_high",  32'(jif.high_jump),  32'(1));
        check("t2_small", 32'(jif.small_jump), 32'(0));
        repeat (3) frame();
        check("t2_high_held", 32'(jif.high_jump), 32'(1));
        jif.playerY = 11'd399;
        tick(1);
        check("t2_air_high", 32'(jif.high_jump), 32'(0));
        jif.playerY = 11'd400;
        jif.space_key = 1'b0;
        jif.enter_key = 1'b0;
        repeat (5) frame();

        // Enter pressed during cooldown: buffered or dropped.
        do_reset();
        jif.space_key = 1'b1;
        tick(2);
        jif.space_key = 1'b0;
        jif.playerY = 11'd399;
        tick(1);
        jif.playerY = 11'd400;
        tick(1);
        frame();
        frame();
        jif.enter_key = 1'b1;
        tick(1);
        frame();
        jif.start_Of_frame = 1'b1;
        tick(1);
        jif.start_Of_frame = 1'b0;
        check("t3_idle_high", 32'(jif.high_jump), 32'(0));
        tick(1);
        check("t3_high",  32'(jif.high_jump),  32'(BufEn ? 1 : 0));
        check("t3_count", 32'(jif.jump_count), 32'(BufEn ? 2 : 1));
        jif.enter_key = 1'b0;
        repeat (10) frame();

        // Space held across a whole jump issues exactly once.
        do_reset();
        jif.space_key = 1'b1;
        tick(2);
        jif.playerY = 11'd399;
        repeat (5) frame();
        jif.playerY = 11'd400;
        repeat (13) frame();
        check("t4_count", 32'(jif.jump_count), 32'(1));
        check("t4_busy",  32'(jif.jump_busy),  32'(0));
        check("t4_small", 32'(jif.small_jump), 32'(0));
        jif.space_key = 1'b0;

        // No lift-off: command released after the issue timeout.
        do_reset();
        jif.space_key = 1'b1;
        tick(2);
        jif.space_key = 1'b0;
        repeat (Timeout - 1) frame();
        check("t5_small_held", 32'(jif.small_jump), 32'(1));
        frame();
        check("t5_small_off", 32'(jif.small_jump), 32'(0));
        check("t5_busy",      32'(jif.jump_busy),  32'(0));
        check("t5_count",     32'(jif.jump_count), 32'(1));

        // Counter wrap, then asynchronous reset while airborne.
        do_reset();
        repeat (255) full_jump();
        check("t6_count_255", 32'(jif.jump_count), 32'(255));
        full_jump();
        check("t6_count_wrap", 32'(jif.jump_count), 32'(0));
        jif.space_key = 1'b1;
        tick(2);
        jif.space_key = 1'b0;
        jif.playerY = 11'd399;
        tick(1);
        check("t6_air_busy", 32'(jif.jump_busy), 32'(1));
        #2 resetN = 1'b0;
        #1;
        check("t6_async_busy",  32'(jif.jump_busy),  32'(0));
        check("t6_async_count", 32'(jif.jump_count), 32'(0));
        check("t6_async_cmd",   32'({jif.small_jump, jif.high_jump}), 32'(0));
        tick(1);
        jif.playerY = 11'd400;
        resetN = 1'b1;

        // Random keys, frames and ground contact, checked every cycle by the model.
        do_reset();
        gnd = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            jif.start_Of_frame = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0)  jif.space_key = ~jif.space_key;
            if ($urandom_range(0, 11) == 0) jif.enter_key = ~jif.enter_key;
            if ($urandom_range(0, 7) == 0)  gnd = ~gnd;
            if (gnd) jif.playerY = 11'd400;
            else     jif.playerY = ($urandom_range(0, 1) == 0) ? 11'd399 : 11'd401;
        end
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
